// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 op codes and execute-stage state encoding.
package riscv_pkg;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational add/sub/compare/logic; shift codes yield zero.
module riscv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            alt,
  output logic [XLEN-1:0] y
);
  always_comb
    y = funct3 == F3_ADD  ? (alt ? a - b : a + b) :
        funct3 == F3_SLT  ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
        funct3 == F3_SLTU ? {{(XLEN-1){1'b0}}, a < b} :
        funct3 == F3_XOR  ? a ^ b :
        funct3 == F3_OR   ? a | b :
        funct3 == F3_AND  ? a & b : '0;
endmodule

// File: rtl/riscv_ex.sv
// riscv_ex: execute stage with registered ALU result and a one-bit-per-cycle
// iterative shifter that stalls upstream while busy.
module riscv_ex
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            exception_in,
  output logic            stall,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result,
  output logic            exception_out
);
  localparam int SW = $clog2(XLEN);
  state_t state, state_nx;
  logic [XLEN-1:0] alu_y, acc, acc_nx;
  logic [SW-1:0] cnt;
  logic [4:0] rd_lat;
  logic left, arith, is_shift, start_shift, last;
  riscv_alu #(.XLEN(XLEN)) u_alu (.a(a), .b(b), .funct3(funct3), .alt(alt), .y(alu_y));
  always_comb begin
    is_shift = funct3 == F3_SLL || funct3 == F3_SR;
    start_shift = valid_in && !exception_in && is_shift && b[SW-1:0] != '0;
    last = cnt == SW'(1);
    acc_nx = left ? {acc[XLEN-2:0], 1'b0} : {arith & acc[XLEN-1], acc[XLEN-1:1]};
  end
  always_comb
    state_nx = state == IDLE ? (start_shift ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  always_comb stall = state == SHIFT;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      valid_out <= 1'b0;
      rd_out <= '0;
      result <= '0;
      exception_out <= 1'b0;
      acc <= '0;
      cnt <= '0;
      rd_lat <= '0;
      left <= 1'b0;
      arith <= 1'b0;
    end else if (state == IDLE) begin
      valid_out <= valid_in && !start_shift;
      if (start_shift) begin
        acc <= a;
        cnt <= b[SW-1:0];
        rd_lat <= rd;
        left <= funct3 == F3_SLL;
        arith <= alt;
      end else if (valid_in) begin
        rd_out <= rd;
        result <= exception_in ? '0 : is_shift ? a : alu_y;
        exception_out <= exception_in;
      end
    end else begin
      acc <= acc_nx;
      cnt <= cnt - SW'(1);
      valid_out <= last;
      if (last) begin
        result <= acc_nx;
        rd_out <= rd_lat;
        exception_out <= 1'b0;
      end
    end
endmodule
